// File: rtl/fast_to_slow_fifo_pkg.sv
// Shared helpers for the fast-to-slow FIFO slice.
package fast_to_slow_fifo_pkg;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fast_to_slow_fifo_store.sv
// Storage array for fast_to_slow_fifo: one synchronous write port, one combinational read port.
module fast_to_slow_fifo_store #(
    parameter int width  = 8,
    parameter int depth  = 4,
    parameter int awidth = 2
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [awidth-1:0] waddr,
    input  logic [width-1:0]  wdata,
    input  logic [awidth-1:0] raddr,
    output logic [width-1:0]  rdata
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fast_to_slow_fifo.sv
// Fast-clocked ring FIFO whose slow-facing view (D_OUT/EMPTY_N) only moves on PREEDGE-qualified edges.
module fast_to_slow_fifo
    import fast_to_slow_fifo_pkg::*;
#(
    parameter int width  = 8,
    parameter int depth  = 4,
    parameter int awidth = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PREEDGE,
    input  logic             ENQ,
    input  logic [width-1:0] D_IN,
    output logic             FULL_N,
    input  logic             DEQ,
    output logic [width-1:0] D_OUT,
    output logic             EMPTY_N
);

    if (width < 1 || !is_pow2(depth) || awidth != $clog2(depth)) begin : g_bad_params
        $fatal(1, "fast_to_slow_fifo: need width>=1, depth a power of two >=2, awidth=log2(depth)");
    end

    localparam logic [awidth:0] DEPTH_C = (awidth + 1)'(depth);

    logic [awidth-1:0] rd_ptr;
    logic [awidth-1:0] wr_ptr;
    logic [awidth-1:0] rd_addr;
    logic [awidth:0]   count;
    logic [awidth:0]   count_next;
    logic [awidth:0]   rem;
    logic [width-1:0]  head;
    logic              push;
    logic              pop;

    assign FULL_N  = (count != DEPTH_C);
    assign push    = ENQ && FULL_N;
    assign pop     = PREEDGE && DEQ && EMPTY_N;
    // Look one entry ahead on a pop so the view lands on the new head at the same edge.
    assign rd_addr = rd_ptr + awidth'(pop);

    always_comb begin
        count_next = count + (awidth + 1)'(push) - (awidth + 1)'(pop);
        rem        = count - (awidth + 1)'(pop);
    end

    fast_to_slow_fifo_store #(
        .width  (width),
        .depth  (depth),
        .awidth (awidth)
    ) u_store (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (D_IN),
        .raddr (rd_addr),
        .rdata (head)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + awidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + awidth'(1);
            end
        end
    end

    // An empty FIFO shows a same-cycle push directly, since storage is written only at this edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            EMPTY_N <= 1'b0;
            D_OUT   <= '0;
        end else if (PREEDGE) begin
            if (rem != '0) begin
                EMPTY_N <= 1'b1;
                D_OUT   <= head;
            end else if (push) begin
                EMPTY_N <= 1'b1;
                D_OUT   <= D_IN;
            end else begin
                EMPTY_N <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fast_to_slow_fifo.sv
// Randomised and directed checks of fast_to_slow_fifo against a queue-based model.
module tb_fast_to_slow_fifo;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PREEDGE;
  logic       ENQ;
  logic [7:0] D_IN;
  logic       FULL_N;
  logic       DEQ;
  logic [7:0] D_OUT;
  logic       EMPTY_N;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic       exp_empty_n = 1'b0;
  logic [7:0] exp_dout = '0;
  logic [7:0] items[5];

  always #5 CLK = ~CLK;

  fast_to_slow_fifo #(
    .width  (8),
    .depth  (D),
    .awidth (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .PREEDGE (PREEDGE),
    .ENQ     (ENQ),
    .D_IN    (D_IN),
    .FULL_N  (FULL_N),
    .DEQ     (DEQ),
    .D_OUT   (D_OUT),
    .EMPTY_N (EMPTY_N)
  );

  task automatic run_cycle(input logic enq, input logic [7:0] din, input logic deq, input logic pe);
    bit push, pop;
    ENQ = enq; D_IN = din; DEQ = deq; PREEDGE = pe;
    push = enq && (q.size() != D);
    pop  = pe && deq && exp_empty_n;
    @(posedge CLK);
    #1;
    if (!RST) begin
      q.delete();
      exp_empty_n = 1'b0;
      exp_dout    = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(din);
      if (pe) begin
        if (q.size() > 0) begin
          exp_empty_n = 1'b1;
          exp_dout    = q[0];
        end else begin
          exp_empty_n = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      run_cycle(1'b1, 8'($urandom), 1'b1, (i % 3) == 2);
      checks++;
      if (EMPTY_N !== 1'b0 || D_OUT !== 8'h00 || FULL_N !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: got empty_n=%b dout=%h full_n=%b, expected 0 00 1",
                 EMPTY_N, D_OUT, FULL_N);
      end
    end
    RST = 1'b1;
    run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (EMPTY_N !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_empty: got empty_n=%b expected 0", EMPTY_N);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      run_cycle(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (FULL_N !== (i < 3)) begin
        errors++;
        $display("FAIL reset_count_zero: after push %0d got full_n=%b expected %b",
                 i + 1, FULL_N, (i < 3));
      end
    end
  endtask

  task automatic test_sequence();
    logic [7:0] obs[$];
    logic [7:0] want[3];
    int         np;
    want = '{8'h11, 8'h22, 8'h33};
    np = 0;
    do_reset();
    for (int unsigned c = 0; c < 12; c++) begin
      bit pe;
      pe = (c % 3) == 2;
      if (!pe && np < 3) begin
        run_cycle(1'b1, want[np], 1'b1, pe);
        np++;
      end else begin
        run_cycle(1'b0, 8'h00, 1'b1, pe);
      end
      if (pe) begin
        obs.push_back(EMPTY_N ? D_OUT : 8'hXX);
        checks++;
        if (EMPTY_N !== exp_empty_n || D_OUT !== exp_dout) begin
          errors++;
          $display("FAIL seq_model: cycle %0d got %b/%h expected %b/%h",
                   c, EMPTY_N, D_OUT, exp_empty_n, exp_dout);
        end
      end
    end
    for (int unsigned k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== want[k]) begin
        errors++;
        $display("FAIL seq_order: edge %0d got %h expected %h", k, obs[k], want[k]);
      end
    end
    checks++;
    if (EMPTY_N !== 1'b0) begin
      errors++;
      $display("FAIL seq_drained: got empty_n=%b expected 0", EMPTY_N);
    end
  endtask

  task automatic test_write_through();
    do_reset();
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    run_cycle(1'b1, 8'hA5, 1'b0, 1'b1);
    checks++;
    if (EMPTY_N !== 1'b1 || D_OUT !== 8'hA5) begin
      errors++;
      $display("FAIL write_through: got %b/%h expected 1/a5", EMPTY_N, D_OUT);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int unsigned i = 0; i < 5; i++) items[i] = 8'($urandom_range(0, 8'hDF));
    for (int unsigned i = 0; i < 5; i++) begin
      run_cycle(1'b1, items[i], 1'b0, (i % 3) == 2);
      checks++;
      if (FULL_N !== (i < 3)) begin
        errors++;
        $display("FAIL fill_full_n: after push %0d got %b expected %b", i + 1, FULL_N, (i < 3));
      end
    end
    for (int unsigned c = 0; c < 9; c++) begin
      run_cycle(1'b0, 8'h00, 1'b0, (c % 3) == 2);
      checks++;
      if (EMPTY_N !== 1'b1 || D_OUT !== items[0] || FULL_N !== 1'b0) begin
        errors++;
        $display("FAIL fill_hold: got %b/%h full_n=%b expected 1/%h full_n=0",
                 EMPTY_N, D_OUT, FULL_N, items[0]);
      end
    end
    for (int unsigned c = 0; c < 8; c++) begin
      run_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if (FULL_N !== 1'b0 || D_OUT !== items[0]) begin
        errors++;
        $display("FAIL fill_frozen: got full_n=%b dout=%h expected 0/%h", FULL_N, D_OUT, items[0]);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] obs[$];
    run_cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    checks++;
    if (FULL_N !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_full_n: got %b expected 1", FULL_N);
    end
    checks++;
    if (EMPTY_N !== 1'b1 || D_OUT !== items[1]) begin
      errors++;
      $display("FAIL full_pop_head: got %b/%h expected 1/%h", EMPTY_N, D_OUT, items[1]);
    end
    obs.push_back(D_OUT);
    for (int unsigned c = 0; c < 15 && EMPTY_N; c++) begin
      run_cycle(1'b0, 8'h00, 1'b1, (c % 3) == 2);
      if ((c % 3) == 2 && EMPTY_N) obs.push_back(D_OUT);
    end
    checks++;
    if (obs.size() != 3) begin
      errors++;
      $display("FAIL full_pop_len: got %0d items expected 3", obs.size());
    end
    for (int unsigned k = 0; k < 3 && k < obs.size(); k++) begin
      checks++;
      if (obs[k] !== items[k + 1]) begin
        errors++;
        $display("FAIL full_pop_order: item %0d got %h expected %h", k, obs[k], items[k + 1]);
      end
    end
    checks++;
    if (EMPTY_N !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_drain: got empty_n=%b expected 0", EMPTY_N);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] obs[$];
    do_reset();
    run_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    run_cycle(1'b1, 8'h6B, 1'b0, 1'b1);
    ENQ = 1'b0; PREEDGE = 1'b0; DEQ = 1'b0;
    #2 RST = 1'b0;
    #1;
    checks++;
    if (EMPTY_N !== 1'b0 || FULL_N !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_immediate: got empty_n=%b full_n=%b expected 0 1", EMPTY_N, FULL_N);
    end
    q.delete();
    exp_empty_n = 1'b0;
    exp_dout    = '0;
    @(posedge CLK);
    #2 RST = 1'b1;
    run_cycle(1'b1, 8'h01, 1'b1, 1'b0);
    run_cycle(1'b1, 8'h02, 1'b1, 1'b0);
    for (int unsigned c = 0; c < 9; c++) begin
      run_cycle(1'b0, 8'h00, 1'b1, (c % 3) == 0);
      if ((c % 3) == 0 && EMPTY_N) obs.push_back(D_OUT);
    end
    checks++;
    if (obs.size() != 2 || obs[0] !== 8'h01 || obs[1] !== 8'h02) begin
      errors++;
      $display("FAIL mid_reset_order: got %0d items first=%h expected 2 items 01 02",
               obs.size(), (obs.size() > 0) ? obs[0] : 8'hXX);
    end
    checks++;
    if (EMPTY_N !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drain: got empty_n=%b expected 0", EMPTY_N);
    end
  endtask

  task automatic test_random();
    logic deq;
    bit   pe;
    int   phase, period, stall;
    deq = 1'b1; phase = 0; period = 3; stall = 0;
    for (int unsigned c = 0; c < 600; c++) begin
      if (stall > 0) begin
        stall--;
        pe = 1'b0;
      end else begin
        pe = (phase == period - 1);
        phase = pe ? 0 : phase + 1;
      end
      run_cycle(($urandom_range(0, 2) != 0), 8'($urandom), deq, pe);
      checks++;
      if (EMPTY_N !== exp_empty_n || D_OUT !== exp_dout || FULL_N !== (q.size() != D)) begin
        errors++;
        $display("FAIL random: cycle %0d got %b/%h full_n=%b expected %b/%h full_n=%b",
                 c, EMPTY_N, D_OUT, FULL_N, exp_empty_n, exp_dout, (q.size() != D));
      end
      if (pe) begin
        deq = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) period = $urandom_range(2, 5);
        if ($urandom_range(0, 19) == 0) stall = $urandom_range(5, 12);
      end
    end
  endtask

  initial begin
    RST = 1'b0; ENQ = 1'b0; DEQ = 1'b0; PREEDGE = 1'b0; D_IN = '0;
    test_reset();
    test_sequence();
    test_write_through();
    test_fill();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
